// File: rtl/uart_pkg.sv
// Shared UART constants: default receive FIFO depth, byte width and bus width.
// Also carries the helper that widens a received byte onto the processor bus.
package uart_pkg;

  localparam int UART_DERINLIK = 16;
  localparam int BAYT_W        = 8;
  localparam int VERI_W        = 32;

  typedef logic [BAYT_W-1:0] bayt_t;
  typedef logic [VERI_W-1:0] veri_t;

  function automatic veri_t bayt_genislet(input bayt_t b);
    return {{(VERI_W-BAYT_W){1'b0}}, b};
  endfunction

endpackage

// File: rtl/uart_al_fifo_bellek.sv
// DERINLIK x 8 storage for the receive FIFO: synchronous write, registered read.
// The read is read-first, so a same-address write returns the old byte.
module uart_al_fifo_bellek
  import uart_pkg::*;
#(
  parameter int DERINLIK = UART_DERINLIK,
  localparam int AW = $clog2(DERINLIK)
) (
  input  logic          clk_g,
  input  logic          yaz_en,
  input  logic [AW-1:0] yaz_adr,
  input  bayt_t         yaz_veri,
  input  logic          oku_en,
  input  logic [AW-1:0] oku_adr,
  output bayt_t         oku_veri
);

  bayt_t mem [DERINLIK];
  bayt_t oku_veri_reg;

  // No reset here so the array maps onto block RAM.
  always_ff @(posedge clk_g) begin
    if (yaz_en) begin
      mem[yaz_adr] <= yaz_veri;
    end
    if (oku_en) begin
      oku_veri_reg <= mem[oku_adr];
    end
  end

  assign oku_veri = oku_veri_reg;

endmodule

// File: rtl/uart_al_fifo.sv
// UART receive FIFO with a one-cycle-latency processor read port.
// Define UART_AL_FIFO_TASMA_EN to enable the sticky overflow flag (tasma).
module uart_al_fifo
  import uart_pkg::*;
#(
  parameter int DERINLIK = UART_DERINLIK
) (
  input  logic                       clk_g,
  input  logic                       rst_g,
  input  logic [BAYT_W-1:0]          al_veri,
  input  logic                       al_gecerli,
  input  logic                       oku_gecerli,
  input  logic                       temizle,
  output logic [VERI_W-1:0]          oku_veri,
  output logic                       oku_veri_gecerli,
  output logic                       bos,
  output logic                       dolu,
  output logic [$clog2(DERINLIK):0]  doluluk,
  output logic                       tasma
);

  localparam int AW = $clog2(DERINLIK);
  localparam int DW = AW + 1;

  logic [AW-1:0] yaz_ptr_reg;
  logic [AW-1:0] oku_ptr_reg;
  logic [DW-1:0] doluluk_reg;
  logic          gecerli_reg;
  logic          bos_oku_reg;
  logic          oku_kabul;
  logic          yaz_kabul;
  bayt_t         bellek_oku;

  assign bos  = (doluluk_reg == '0);
  assign dolu = (doluluk_reg == DW'(DERINLIK));

  // A read frees a slot in the same cycle, so a full FIFO still takes a write
  // when a read is accepted alongside it; flush overrides both.
  assign oku_kabul = oku_gecerli & ~bos & ~temizle;
  assign yaz_kabul = al_gecerli & ~temizle & (~dolu | oku_kabul);

  always_ff @(posedge clk_g) begin
    if (rst_g) begin
      yaz_ptr_reg <= '0;
      oku_ptr_reg <= '0;
      doluluk_reg <= '0;
      gecerli_reg <= 1'b0;
      bos_oku_reg <= 1'b1;
    end else if (temizle) begin
      yaz_ptr_reg <= '0;
      oku_ptr_reg <= '0;
      doluluk_reg <= '0;
      gecerli_reg <= 1'b0;
    end else begin
      if (yaz_kabul) begin
        yaz_ptr_reg <= yaz_ptr_reg + AW'(1);
      end
      if (oku_kabul) begin
        oku_ptr_reg <= oku_ptr_reg + AW'(1);
      end
      case ({yaz_kabul, oku_kabul})
        2'b10:   doluluk_reg <= doluluk_reg + DW'(1);
        2'b01:   doluluk_reg <= doluluk_reg - DW'(1);
        default: doluluk_reg <= doluluk_reg;
      endcase
      gecerli_reg <= oku_gecerli;
      // Remembers whether the last read hit an empty FIFO; the RAM output
      // register is left untouched then, so the bus is forced to zero instead.
      if (oku_gecerli) begin
        bos_oku_reg <= bos;
      end
    end
  end

  uart_al_fifo_bellek #(
    .DERINLIK (DERINLIK)
  ) u_bellek (
    .clk_g    (clk_g),
    .yaz_en   (yaz_kabul),
    .yaz_adr  (yaz_ptr_reg),
    .yaz_veri (al_veri),
    .oku_en   (oku_kabul),
    .oku_adr  (oku_ptr_reg),
    .oku_veri (bellek_oku)
  );

  assign oku_veri         = bos_oku_reg ? '0 : bayt_genislet(bellek_oku);
  assign oku_veri_gecerli = gecerli_reg;
  assign doluluk          = doluluk_reg;

`ifdef UART_AL_FIFO_TASMA_EN
  logic tasma_reg;

  always_ff @(posedge clk_g) begin
    if (rst_g || temizle) begin
      tasma_reg <= 1'b0;
    end else if (al_gecerli && !yaz_kabul) begin
      tasma_reg <= 1'b1;
    end
  end

  assign tasma = tasma_reg;
`else
  assign tasma = 1'b0;
`endif

endmodule
